// File: rtl/alu_writeback_stage_if.sv
// ---------------------------------------------------------------------------
// alu_writeback_stage_if
//   Bundles the ALU-side input handshake, the register-file-side output
//   handshake, the flush strobe and the condition-code query port of
//   alu_writeback_stage.
//
//   Upstream   : I_VALID / O_READY, with I_RESULT, I_STATUS, I_OPCODE, I_DEST,
//                I_WRITE_EN and I_SET_FLAGS as the entry payload
//   Downstream : O_VALID / I_READY, with O_RESULT, O_DEST, O_WRITE_EN
//   Control    : I_FLUSH discards every buffered entry
//   Status     : O_PSR (committed PSR), I_COND -> O_COND_TRUE
//
//   modport slave  : the stage's view (drives the O_* signals)
//   modport master : the environment's view (drives the I_* signals)
// ---------------------------------------------------------------------------
interface alu_writeback_stage_if #(
  parameter int P_WIDTH    = 16,
  parameter int P_REG_BITS = 4
);
  logic                  I_VALID;
  logic                  O_READY;
  logic [P_WIDTH-1:0]    I_RESULT;
  logic [4:0]            I_STATUS;
  logic [3:0]            I_OPCODE;
  logic [P_REG_BITS-1:0] I_DEST;
  logic                  I_WRITE_EN;
  logic                  I_SET_FLAGS;
  logic                  I_FLUSH;
  logic                  O_VALID;
  logic                  I_READY;
  logic [P_WIDTH-1:0]    O_RESULT;
  logic [P_REG_BITS-1:0] O_DEST;
  logic                  O_WRITE_EN;
  logic [4:0]            O_PSR;
  logic [3:0]            I_COND;
  logic                  O_COND_TRUE;

  modport slave (
    input  I_VALID, I_RESULT, I_STATUS, I_OPCODE, I_DEST, I_WRITE_EN,
           I_SET_FLAGS, I_FLUSH, I_READY, I_COND,
    output O_READY, O_VALID, O_RESULT, O_DEST, O_WRITE_EN, O_PSR, O_COND_TRUE
  );

  modport master (
    output I_VALID, I_RESULT, I_STATUS, I_OPCODE, I_DEST, I_WRITE_EN,
           I_SET_FLAGS, I_FLUSH, I_READY, I_COND,
    input  O_READY, O_VALID, O_RESULT, O_DEST, O_WRITE_EN, O_PSR, O_COND_TRUE
  );
endinterface

// File: rtl/alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// alu_writeback_stage
//   Execute-to-writeback stage behind the CR16 ALU. Holds up to two ALU
//   results in an in-order circular buffer, presents the head entry to the
//   register file, commits the PSR in program order using per-opcode flag
//   masks, and evaluates CR16 branch/Scond condition codes.
//
//   Ports:
//     I_CLK   : clock, every state update happens on its rising edge
//     I_RESET : synchronous, active-high reset
//     bus     : alu_writeback_stage_if.slave (handshakes, payload, flush,
//               PSR and condition-code port)
//
//   Optional feature (macro ALU_WB_FLAG_FORWARD_EN):
//     When defined, O_COND_TRUE is evaluated against the PSR the valid head
//     entry would produce on commit, so a branch sees the flags one entry
//     early. O_PSR itself still changes only on pop.
// ---------------------------------------------------------------------------
module alu_writeback_stage #(
  parameter int P_WIDTH    = 16,
  parameter int P_REG_BITS = 4
) (
  input logic                  I_CLK,
  input logic                  I_RESET,
  alu_writeback_stage_if.slave bus
);

  typedef struct packed {
    logic [P_WIDTH-1:0]    result;
    logic [P_REG_BITS-1:0] dest;
    logic [3:0]            opcode;
    logic [4:0]            status;
    logic                  write_en;
    logic                  set_flags;
  } entry_t;

  // PSR bit positions: 0 C, 1 L, 2 F, 3 Z, 4 N
  localparam int Z_BIT = 3;

  // PSR after committing entry e on top of psr.
  function automatic logic [4:0] commit_psr(input logic [4:0] psr, input entry_t e);
    logic [4:0] nxt;
    nxt = psr;
    if (e.set_flags) begin
      case (e.opcode)
        4'd0, 4'd1, 4'd3:                    nxt = e.status;            // ADD/ADDC/SUB
        4'd4, 4'd5, 4'd6, 4'd7,
        4'd8, 4'd9, 4'd10, 4'd11:            nxt[Z_BIT] = e.status[Z_BIT]; // logic/shift
        default:                             nxt = psr;                 // MUL, 12-15
      endcase
    end
    return nxt;
  endfunction

  function automatic logic eval_cond(input logic [3:0] cond, input logic [4:0] psr);
    logic c, l, f, z, n;
    {n, z, f, l, c} = psr;
    case (cond)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return c;
      4'd3:    return !c;
      4'd4:    return l;
      4'd5:    return !l;
      4'd6:    return n;
      4'd7:    return !n;
      4'd8:    return f;
      4'd9:    return !f;
      4'd10:   return !l && !z;
      4'd11:   return l || z;
      4'd12:   return !n && !z;
      4'd13:   return n || z;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  entry_t     head_q, head_d;     // registered copy of the head; holds when empty
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [4:0] psr_q, psr_d;

  logic   push, pop;
  entry_t in_entry;
  logic [4:0] cond_psr;

  always_comb begin
    in_entry = '{result:    bus.I_RESULT,
                 dest:      bus.I_DEST,
                 opcode:    bus.I_OPCODE,
                 status:    bus.I_STATUS,
                 write_en:  bus.I_WRITE_EN,
                 set_flags: bus.I_SET_FLAGS};

    push = bus.I_VALID && (count_q != 2'd2);
    pop  = (count_q != 2'd0) && bus.I_READY;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    mem_d    = mem_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    psr_d    = psr_q;

    if (bus.I_FLUSH) begin
      // Flush wins over a same-cycle push (dropped) and pop (no commit).
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        psr_d    = commit_psr(psr_q, head_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end

    // The head register tracks the next head so the entry appears one edge
    // after its push; when the buffer drains it keeps the last value.
    head_d = (count_d != 2'd0) ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge I_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (I_RESET) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      head_q   <= '0;
      psr_q    <= 5'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      head_q   <= head_d;
      psr_q    <= psr_d;
    end
  end

  // NOTE: buffer storage is left out of reset; occupancy alone decides
  // whether a slot is meaningful, so clearing it would only cost reset fan-out.
  always_ff @(posedge I_CLK) begin
    mem_q <= mem_d;
  end

`ifdef ALU_WB_FLAG_FORWARD_EN
  // Only the head may be forwarded; the second entry waits its turn.
  assign cond_psr = (count_q != 2'd0) ? commit_psr(psr_q, head_q) : psr_q;
`else
  assign cond_psr = psr_q;
`endif

  assign bus.O_READY     = (count_q != 2'd2);
  assign bus.O_VALID     = (count_q != 2'd0);
  assign bus.O_RESULT    = head_q.result;
  assign bus.O_DEST      = head_q.dest;
  assign bus.O_WRITE_EN  = (count_q != 2'd0) && head_q.write_en;
  assign bus.O_PSR       = psr_q;
  assign bus.O_COND_TRUE = eval_cond(bus.I_COND, cond_psr);

endmodule

// File: tb/tb_alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback_stage
//   Directed self-checking bench for alu_writeback_stage. Inputs change #1
//   after the rising edge and outputs are compared in the same window.
//   Honours ALU_WB_FLAG_FORWARD_EN for the forwarding check.
// ---------------------------------------------------------------------------
module tb_alu_writeback_stage;

`ifdef ALU_WB_FLAG_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic I_CLK;
  logic I_RESET;

  alu_writeback_stage_if #(.P_WIDTH(16), .P_REG_BITS(4)) bus ();

  alu_writeback_stage #(.P_WIDTH(16), .P_REG_BITS(4)) dut (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .bus     (bus)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  // Offer one entry for exactly one edge.
  task automatic send(input logic [3:0] op, input logic [15:0] res, input logic [4:0] st,
                      input logic [3:0] dest, input logic we, input logic sf);
    bus.I_OPCODE    = op;
    bus.I_RESULT    = res;
    bus.I_STATUS    = st;
    bus.I_DEST      = dest;
    bus.I_WRITE_EN  = we;
    bus.I_SET_FLAGS = sf;
    bus.I_VALID     = 1'b1;
    step();
    bus.I_VALID     = 1'b0;
  endtask

  logic [15:0] cond_exp;

  initial begin
    bus.I_VALID = 0; bus.I_RESULT = 0; bus.I_STATUS = 0; bus.I_OPCODE = 0;
    bus.I_DEST = 0; bus.I_WRITE_EN = 0; bus.I_SET_FLAGS = 0; bus.I_FLUSH = 0;
    bus.I_READY = 0; bus.I_COND = 0;

    // ---- reset ----
    I_RESET = 1'b1;
    step();
    step();
    I_RESET = 1'b0;
    check("rst_valid", 32'(bus.O_VALID), 32'd0);
    check("rst_ready", 32'(bus.O_READY), 32'd1);
    check("rst_result", 32'(bus.O_RESULT), 32'd0);
    check("rst_dest", 32'(bus.O_DEST), 32'd0);
    check("rst_we", 32'(bus.O_WRITE_EN), 32'd0);
    check("rst_psr", 32'(bus.O_PSR), 32'd0);

    // ---- ADD push, 1-cycle latency, commit ----
    bus.I_READY = 1'b1;
    send(4'd0, 16'h0000, 5'b01001, 4'd3, 1'b1, 1'b1);
    check("add_valid", 32'(bus.O_VALID), 32'd1);
    check("add_result", 32'(bus.O_RESULT), 32'd0);
    check("add_dest", 32'(bus.O_DEST), 32'd3);
    check("add_we", 32'(bus.O_WRITE_EN), 32'd1);
    check("add_psr_before_pop", 32'(bus.O_PSR), 32'd0);
    step();
    check("add_psr", 32'(bus.O_PSR), 32'b01001);
    check("add_empty_valid", 32'(bus.O_VALID), 32'd0);
    check("add_empty_we", 32'(bus.O_WRITE_EN), 32'd0);
    check("add_empty_dest_hold", 32'(bus.O_DEST), 32'd3);
    // PSR 01001: C=1 L=0 F=0 Z=1 N=0
    cond_exp = 16'h6AA5;
    for (int i = 0; i < 16; i++) begin
      bus.I_COND = 4'(i);
      #1;
      check($sformatf("cond_%0d", i), 32'(bus.O_COND_TRUE), 32'(cond_exp[i]));
    end

    // ---- flag masks ----
    send(4'd0, 16'h1111, 5'b10111, 4'd1, 1'b1, 1'b1);
    step();
    check("psr_10111", 32'(bus.O_PSR), 32'b10111);
    send(4'd7, 16'h2222, 5'b01000, 4'd1, 1'b1, 1'b1);
    step();
    check("xor_z_only", 32'(bus.O_PSR), 32'b11111);
    send(4'd2, 16'h3333, 5'b00000, 4'd1, 1'b1, 1'b1);
    step();
    check("mul_no_flags", 32'(bus.O_PSR), 32'b11111);
    send(4'd0, 16'h4444, 5'b00000, 4'd1, 1'b1, 1'b0);
    step();
    check("unflagged_add", 32'(bus.O_PSR), 32'b11111);

    // ---- backpressure, fill to 2, drain in order across wrap ----
    bus.I_READY = 1'b0;
    bus.I_OPCODE = 4'd0; bus.I_STATUS = 5'b0; bus.I_DEST = 4'd5;
    bus.I_WRITE_EN = 1'b1; bus.I_SET_FLAGS = 1'b0;
    bus.I_VALID = 1'b1;
    bus.I_RESULT = 16'd1;
    check("bp_ready0", 32'(bus.O_READY), 32'd1);
    step();
    bus.I_RESULT = 16'd2;
    check("bp_ready1", 32'(bus.O_READY), 32'd1);
    check("bp_head1", 32'(bus.O_RESULT), 32'd1);
    step();
    bus.I_RESULT = 16'd3;
    check("bp_full_ready", 32'(bus.O_READY), 32'd0);
    check("bp_full_head", 32'(bus.O_RESULT), 32'd1);
    step();
    check("bp_held_ready", 32'(bus.O_READY), 32'd0);
    check("bp_held_head", 32'(bus.O_RESULT), 32'd1);
    bus.I_READY = 1'b1;
    step();
    check("bp_drain_2", 32'(bus.O_RESULT), 32'd2);
    check("bp_drain_ready", 32'(bus.O_READY), 32'd1);
    step();
    bus.I_VALID = 1'b0;
    check("bp_drain_3", 32'(bus.O_RESULT), 32'd3);
    check("bp_drain_3_valid", 32'(bus.O_VALID), 32'd1);
    step();
    check("bp_empty_valid", 32'(bus.O_VALID), 32'd0);
    check("bp_empty_hold", 32'(bus.O_RESULT), 32'd3);
    check("bp_psr_untouched", 32'(bus.O_PSR), 32'b11111);

    // ---- streaming at occupancy 1 ----
    bus.I_VALID = 1'b1;
    bus.I_RESULT = 16'd100;
    step();
    for (int i = 1; i <= 10; i++) begin
      bus.I_RESULT = 16'(100 + i);
      check("stream_valid", 32'(bus.O_VALID), 32'd1);
      check("stream_ready", 32'(bus.O_READY), 32'd1);
      check($sformatf("stream_res_%0d", i), 32'(bus.O_RESULT), 32'(100 + i - 1));
      step();
    end
    bus.I_VALID = 1'b0;
    check("stream_last", 32'(bus.O_RESULT), 32'd110);
    step();
    check("stream_empty", 32'(bus.O_VALID), 32'd0);

    // ---- flush at occupancy 2 with push and pop offered ----
    bus.I_READY = 1'b0;
    bus.I_SET_FLAGS = 1'b1; bus.I_STATUS = 5'b00000; bus.I_OPCODE = 4'd0;
    bus.I_VALID = 1'b1;
    bus.I_RESULT = 16'h0050;
    step();
    bus.I_RESULT = 16'h0051;
    step();
    check("flush_pre_full", 32'(bus.O_READY), 32'd0);
    bus.I_FLUSH = 1'b1;
    bus.I_READY = 1'b1;
    bus.I_RESULT = 16'h0052;
    step();
    bus.I_FLUSH = 1'b0;
    bus.I_VALID = 1'b0;
    check("flush_valid", 32'(bus.O_VALID), 32'd0);
    check("flush_ready", 32'(bus.O_READY), 32'd1);
    check("flush_psr", 32'(bus.O_PSR), 32'b11111);
    check("flush_we", 32'(bus.O_WRITE_EN), 32'd0);
    check("flush_result_hold", 32'(bus.O_RESULT), 32'h50);
    step();
    check("flush_push_lost", 32'(bus.O_VALID), 32'd0);
    check("flush_psr_later", 32'(bus.O_PSR), 32'b11111);

    // ---- condition evaluation with a flagged head waiting ----
    send(4'd0, 16'h0077, 5'b00000, 4'd2, 1'b1, 1'b1);
    step();
    check("fwd_psr_zero", 32'(bus.O_PSR), 32'd0);
    bus.I_COND = 4'd10;
    #1;
    check("cond_lo_psr0", 32'(bus.O_COND_TRUE), 32'd1);
    bus.I_COND = 4'd12;
    #1;
    check("cond_lt_psr0", 32'(bus.O_COND_TRUE), 32'd1);
    bus.I_READY = 1'b0;
    send(4'd3, 16'h0000, 5'b01000, 4'd4, 1'b1, 1'b1);
    bus.I_COND = 4'd0;
    #1;
    check("fwd_eq", 32'(bus.O_COND_TRUE), 32'(FWD));
    bus.I_COND = 4'd1;
    #1;
    check("fwd_ne", 32'(bus.O_COND_TRUE), 32'(!FWD));
    check("fwd_psr_held", 32'(bus.O_PSR), 32'd0);
    bus.I_READY = 1'b1;
    step();
    bus.I_COND = 4'd0;
    #1;
    check("sub_psr", 32'(bus.O_PSR), 32'b01000);
    check("sub_eq", 32'(bus.O_COND_TRUE), 32'd1);

    // ---- reset mid-operation ----
    bus.I_READY = 1'b0;
    send(4'd0, 16'h0099, 5'b10101, 4'd6, 1'b1, 1'b1);
    check("mid_valid_pre", 32'(bus.O_VALID), 32'd1);
    I_RESET = 1'b1;
    step();
    I_RESET = 1'b0;
    check("mid_rst_valid", 32'(bus.O_VALID), 32'd0);
    check("mid_rst_psr", 32'(bus.O_PSR), 32'd0);
    check("mid_rst_ready", 32'(bus.O_READY), 32'd1);
    check("mid_rst_result", 32'(bus.O_RESULT), 32'd0);
    check("mid_rst_dest", 32'(bus.O_DEST), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Execute-to-writeback pipeline stage directly downstream of the CR16 ALU.
- Registers the ALU result and 5-bit status into a 2-entry in-order buffer with valid/ready handshakes.
- Commits the processor status register (PSR) in program order, using per-opcode flag masks.
- Evaluates CR16 branch/Scond condition codes against the committed PSR.

Parameters:
P_WIDTH, 16, width of result datapath
P_REG_BITS, 4, width of destination register index

Ports:
I_CLK  input  1  clock, all state updates on rising edge
I_RESET  input  1  synchronous, active-high reset
I_VALID  input  1  upstream entry valid
O_READY  output  1  stage can accept an entry; high when occupancy < 2 (registered, no combinational path from I_READY)
I_RESULT  input  P_WIDTH  ALU result
I_STATUS  input  5  ALU status: bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N
I_OPCODE  input  4  ALU opcode that produced the entry
I_DEST  input  P_REG_BITS  destination register index
I_WRITE_EN  input  1  entry writes a register (0 for CMP)
I_SET_FLAGS  input  1  entry updates PSR
I_FLUSH  input  1  discard all buffered entries
O_VALID  output  1  head entry valid
I_READY  input  1  register file accepts head entry
O_RESULT  output  P_WIDTH  head result
O_DEST  output  P_REG_BITS  head destination
O_WRITE_EN  output  1  head write enable, gated by O_VALID
O_PSR  output  5  committed status register, same bit order as I_STATUS
I_COND  input  4  condition code to evaluate
O_COND_TRUE  output  1  combinational condition result

Behaviour:
- Clock and reset: one clock I_CLK; reset I_RESET is synchronous and active-high.
- Reset values: occupancy 0, O_VALID 0, O_RESULT 0, O_DEST 0, O_WRITE_EN 0, O_PSR 5'b0, O_READY 1.
- Push and pop:
  - Push when I_VALID & O_READY.
  - Pop when O_VALID & I_READY.
  - Circular 2-entry buffer with read/write pointers wrapping 1->0.
- Latency: an entry pushed at edge n is presented on O_* after edge n (1-cycle latency).
- Occupancy transitions:
  - 0 -> 1 on push.
  - 1 -> 2 on push without pop.
  - 1 stays 1 on simultaneous push and pop.
  - 2 -> 1 on pop.
  - Push is impossible at 2 because O_READY = 0.
- Empty: O_VALID = 0, O_WRITE_EN = 0, O_RESULT/O_DEST hold their last value. Popping when empty is a no-op.
- Commit: on pop with head set_flags = 1, O_PSR updates at that edge by head opcode:
  - Opcodes 0, 1, 3 (ADD, ADDC, SUB): all 5 bits replaced.
  - Opcodes 4–11 (logic/shift): only Z replaced; C, L, F, N retained.
  - Opcode 2 (MUL) and 12–15: PSR unchanged.
- Unflagged entries: set_flags = 0 never alters PSR.
- Flush:
  - I_FLUSH = 1 sets occupancy to 0 and pointers to 0 at the next edge.
  - Flush overrides a same-cycle push (the entry is dropped) and a same-cycle pop (no PSR commit).
  - O_PSR is unaffected by flush.
- Reset mid-operation: buffered entries are discarded and the PSR is cleared.
- O_COND_TRUE, from O_PSR:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - 10 LO: !L & !Z
  - 11 HS: L | Z
  - 12 LT: !N & !Z
  - 13 GE: N | Z
  - 14 UC: 1
  - 15: 0

Optional Feature:
- Macro: ALU_WB_FLAG_FORWARD_EN.
- Defined:
  - O_COND_TRUE evaluates against the forwarded PSR: the value O_PSR would take if the current head entry (O_VALID = 1, set_flags = 1) committed, using the same mask rules.
  - The second buffered entry is never forwarded.
  - O_PSR itself is still committed only on pop.
- Undefined: O_COND_TRUE uses O_PSR only, with no bypass logic.

Test Plan:
- Reset, then push ADD (opcode 0, result 16'h0000, status 5'b01001, dest 3, we 1, sf 1) with I_READY = 1:
  - Cycle after push: O_VALID = 1, O_RESULT = 0, O_DEST = 3.
  - After pop: O_PSR = 5'b01001, I_COND = 0 -> O_COND_TRUE = 1.
- PSR = 5'b10111, then commit XOR (opcode 7, status 5'b01000, sf 1):
  - O_PSR = 5'b11111, since only Z is replaced.
  - Then commit MUL with sf 1: O_PSR stays 5'b11111.
- Hold I_READY = 0 and offer 3 entries (results 1, 2, 3):
  - O_READY drops after the 2nd push; the 3rd is held upstream.
  - Raise I_READY: O_RESULT sequence is 1, 2, 3, in order across pointer wrap.
- Occupancy 1, with push and pop in the same cycle for 10 cycles:
  - Occupancy stays 1, O_READY stays 1.
  - Results emerge in order with no bubble.
- Occupancy 2, assert I_FLUSH with I_VALID = 1 and I_READY = 1:
  - Next cycle: O_VALID = 0, O_READY = 1.
  - O_PSR is unchanged and the pushed entry is lost.
- With ALU_WB_FLAG_FORWARD_EN defined: head is SUB with status Z = 1, sf 1, I_READY = 0, O_PSR Z = 0.
  - I_COND = 0 -> O_COND_TRUE = 1.
  - Without the macro -> O_COND_TRUE = 0.
